// File: rtl/hctrl_pkg.sv
// Shared types and constants for the hand-controller scanner and the I/O register block.
package hctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_UPDATE
  } state_t;

  localparam int unsigned DEF_NUM_CTRL = 2;
  localparam int unsigned DEF_BITS     = 8;
  localparam int unsigned DEF_DIV_HALF = 128;
  localparam int unsigned DEF_DEBOUNCE = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hctrl_debounce.sv
// Frame debounce: accepts a frame once enough identical frames in a row have been seen,
// then flags which controllers' slices changed.
module hctrl_debounce
  import hctrl_pkg::*;
#(
  parameter int unsigned NUM_CTRL = DEF_NUM_CTRL,
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_strobe,
  input  logic [NUM_CTRL*BITS-1:0] frame,
  output logic [NUM_CTRL*BITS-1:0] ctrl_data,
  output logic [NUM_CTRL-1:0]      changed,
  output logic                     frame_done
);

  localparam int unsigned N  = NUM_CTRL * BITS;
  localparam int unsigned MW = cw(DEBOUNCE);

  logic [N-1:0]        prev;
  logic [MW-1:0]       match_cnt;
  logic [MW-1:0]       match_nxt;
  logic                accept;
  logic [NUM_CTRL-1:0] diff;

  always_comb begin
    match_nxt = '0;
    if (frame == prev) begin
      match_nxt = (match_cnt == MW'(DEBOUNCE - 1)) ? match_cnt : match_cnt + MW'(1);
    end
    accept = (match_nxt == MW'(DEBOUNCE - 1));
    diff   = '0;
    for (int unsigned c = 0; c < NUM_CTRL; c++) begin
      diff[c] = (frame[c*BITS +: BITS] != ctrl_data[c*BITS +: BITS]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      match_cnt  <= '0;
      ctrl_data  <= '1;
      changed    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_strobe;
      changed    <= '0;
      if (frame_strobe) begin
        prev      <= frame;
        match_cnt <= match_nxt;
        if (accept) begin
          ctrl_data <= frame;
          changed   <= diff;
        end
      end
    end
  end

endmodule

// File: rtl/hctrl_scanner.sv
// Serial scanner for a 74HC165-style chain: LOAD#/CLK generation, bit capture and
// hand-off of each complete frame to the debounce stage.
module hctrl_scanner
  import hctrl_pkg::*;
#(
  parameter int unsigned NUM_CTRL = DEF_NUM_CTRL,
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned DIV_HALF = DEF_DIV_HALF,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_en,
  output logic                     hctrl_clk,
  output logic                     hctrl_load_n,
  input  logic                     hctrl_data,
  output logic [NUM_CTRL*BITS-1:0] ctrl_data,
  output logic [NUM_CTRL-1:0]      changed,
  output logic                     frame_done
);

  localparam int unsigned N  = NUM_CTRL * BITS;
  localparam int unsigned DW = cw(2 * DIV_HALF);
  localparam int unsigned BW = cw(N);

  state_t        state;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      hctrl_clk    <= 1'b0;
      hctrl_load_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scan_en) begin
            state        <= ST_LOAD;
            div          <= '0;
            hctrl_load_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (div == DW'(2 * DIV_HALF - 1)) begin
            state        <= ST_SHIFT;
            div          <= '0;
            bit_cnt      <= '0;
            hctrl_load_n <= 1'b1;
          end else begin
            div <= div + DW'(1);
          end
        end
        ST_SHIFT: begin
          if (div == DW'(DIV_HALF - 1)) begin
            div       <= '0;
            hctrl_clk <= ~hctrl_clk;
            // Sample QH just before issuing the rising edge that shifts the chain.
            if (!hctrl_clk) begin
              shreg <= (shreg << 1) | N'(hctrl_data);
              if (bit_cnt == BW'(N - 1)) begin
                state <= ST_UPDATE;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        ST_UPDATE: begin
          hctrl_clk <= 1'b0;
          div       <= '0;
          if (scan_en) begin
            state        <= ST_LOAD;
            hctrl_load_n <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hctrl_debounce #(
    .NUM_CTRL(NUM_CTRL),
    .BITS    (BITS),
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .frame_strobe(state == ST_UPDATE),
    .frame       (shreg),
    .ctrl_data   (ctrl_data),
    .changed     (changed),
    .frame_done  (frame_done)
  );

endmodule

// File: tb/tb_hctrl_scanner.sv
// Bench: three scanner configurations, each driven by a modelled 74HC165 chain, checked
// every cycle against a frame-timeline/debounce model plus directed literal expectations.
module tb_hctrl_scanner;

  localparam int DH = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic [2:0]  hclk;
  logic [2:0]  loadn;
  logic [2:0]  hdat;
  logic [2:0]  fdone;
  logic [15:0] cd_a, cd_b;
  logic [17:0] cd_c;
  logic [1:0]  ch_a, ch_b;
  logic [2:0]  ch_c;
  logic [17:0] cd [3];
  logic [2:0]  ch [3];

  logic [17:0] pattern [3];
  logic [17:0] chain [3];
  logic [2:0]  hclk_q;

  int  errors = 0;
  int  checks = 0;
  bit  chk_on = 0;

  // model state
  bit          m_act [3];
  int          m_p [3];
  int          m_run [3];
  bit          m_fd [3];
  logic [17:0] m_ctrl [3];
  logic [17:0] m_prev [3];
  logic [17:0] m_frame [3];
  logic [2:0]  m_chg [3];

  hctrl_scanner #(.NUM_CTRL(2), .BITS(8), .DIV_HALF(DH), .DEBOUNCE(1)) u_a (
    .clk(clk), .reset(reset), .scan_en(en[0]), .hctrl_clk(hclk[0]), .hctrl_load_n(loadn[0]),
    .hctrl_data(hdat[0]), .ctrl_data(cd_a), .changed(ch_a), .frame_done(fdone[0]));

  hctrl_scanner #(.NUM_CTRL(2), .BITS(8), .DIV_HALF(DH), .DEBOUNCE(2)) u_b (
    .clk(clk), .reset(reset), .scan_en(en[1]), .hctrl_clk(hclk[1]), .hctrl_load_n(loadn[1]),
    .hctrl_data(hdat[1]), .ctrl_data(cd_b), .changed(ch_b), .frame_done(fdone[1]));

  hctrl_scanner #(.NUM_CTRL(3), .BITS(6), .DIV_HALF(DH), .DEBOUNCE(1)) u_c (
    .clk(clk), .reset(reset), .scan_en(en[2]), .hctrl_clk(hclk[2]), .hctrl_load_n(loadn[2]),
    .hctrl_data(hdat[2]), .ctrl_data(cd_c), .changed(ch_c), .frame_done(fdone[2]));

  assign cd[0] = {2'b00, cd_a};
  assign cd[1] = {2'b00, cd_b};
  assign cd[2] = cd_c;
  assign ch[0] = {1'b0, ch_a};
  assign ch[1] = {1'b0, ch_b};
  assign ch[2] = ch_c;

  function automatic int nb(input int i);    return (i == 2) ? 18 : 16; endfunction
  function automatic int nctl(input int i);  return (i == 2) ? 3 : 2;   endfunction
  function automatic int bitsc(input int i); return (i == 2) ? 6 : 8;   endfunction
  function automatic int deb(input int i);   return (i == 1) ? 2 : 1;   endfunction

  function automatic logic [17:0] ones(input int i);
    return 18'((64'd1 << nb(i)) - 64'd1);
  endfunction

  function automatic logic [2:0] slice_diff(input logic [17:0] a, input logic [17:0] b, input int i);
    logic [2:0] d;
    logic [17:0] m;
    d = '0;
    m = 18'((64'd1 << bitsc(i)) - 64'd1);
    for (int c = 0; c < nctl(i); c++)
      if (((a >> (c * bitsc(i))) & m) != ((b >> (c * bitsc(i))) & m)) d[c] = 1'b1;
    return d;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74HC165 chain: transparent parallel load while LOAD# low, shift on CLK rise, SER tied high
  always_comb
    for (int i = 0; i < 3; i++) hdat[i] = chain[i][nb(i)-1];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!loadn[i]) chain[i] <= pattern[i];
      else if (hclk[i] && !hclk_q[i]) chain[i] <= {chain[i][16:0], 1'b1};
    end
    hclk_q <= hclk;
  end

  // Model: frame timeline by position p within a frame, debounce by run length of equal frames
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int fl, np, nrun;
      bit na, nfd;
      logic [17:0] nctrl, nfrm, nprev;
      logic [2:0] nchg;
      fl    = 2*DH + (2*nb(i) - 1)*DH + 1;
      na    = m_act[i];
      np    = m_p[i];
      nrun  = m_run[i];
      nctrl = m_ctrl[i];
      nfrm  = m_frame[i];
      nprev = m_prev[i];
      nfd   = 1'b0;
      nchg  = '0;
      if (reset) begin
        na = 1'b0; np = 0; nctrl = ones(i); nprev = '0; nrun = 1;
      end else if (!na) begin
        if (en[i]) begin na = 1'b1; np = 0; end
      end else if (np == fl - 1) begin
        nrun  = (nfrm == nprev) ? nrun + 1 : 1;
        nprev = nfrm;
        nfd   = 1'b1;
        if (nrun >= deb(i)) begin
          nchg  = slice_diff(nctrl, nfrm, i);
          nctrl = nfrm;
        end
        if (en[i]) np = 0; else na = 1'b0;
      end else begin
        if (np == 2*DH - 1) nfrm = pattern[i];
        np = np + 1;
      end
      m_act[i]   <= na;
      m_p[i]     <= np;
      m_run[i]   <= nrun;
      m_ctrl[i]  <= nctrl;
      m_frame[i] <= nfrm;
      m_prev[i]  <= nprev;
      m_fd[i]    <= nfd;
      m_chg[i]   <= nchg;
    end
  end

  task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        int  o;
        bit  e_ld, e_ck;
        o    = m_p[i] - 2*DH;
        e_ld = !(m_act[i] && m_p[i] < 2*DH);
        e_ck = m_act[i] && (m_p[i] >= 2*DH) && ((o / DH) % 2 == 1);
        check("load_n",     i, 32'(loadn[i]), 32'(e_ld));
        check("hctrl_clk",  i, 32'(hclk[i]),  32'(e_ck));
        check("frame_done", i, 32'(fdone[i]), 32'(m_fd[i]));
        check("ctrl_data",  i, 32'(cd[i]),    32'(m_ctrl[i]));
        check("changed",    i, 32'(ch[i]),    32'(m_chg[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int i, output int k);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!fdone[i] && k < 400);
    if (!fdone[i]) check("fd_timeout", i, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, fdk, lows, rises, first, last, gmin, gmax, fds;
    bit  prev_h;
    reset = 1'b1;
    en    = '0;
    for (int i = 0; i < 3; i++) pattern[i] = '1;
    tick(1);
    chk_on = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_ctrl", 0, 32'(cd_a), 32'h0000FFFF);
    check("rst_ldn",  0, 32'(loadn[0]), 32'd1);

    // Frame timing and first accept with DEBOUNCE=1
    pattern[0] = 18'h0A55A;
    en[0] = 1'b1;
    k = 0; fdk = 0; lows = 0; rises = 0; first = 0; last = 0; gmin = 999; gmax = 0; prev_h = 1'b0;
    while (fdk == 0 && k < 300) begin
      tick(1);
      k++;
      if (hclk[0] && !prev_h) begin
        rises++;
        if (rises == 1) first = k;
        else begin
          if (k - last < gmin) gmin = k - last;
          if (k - last > gmax) gmax = k - last;
        end
        last = k;
      end
      prev_h = hclk[0];
      if (fdone[0]) fdk = k;
      else if (!loadn[0]) lows++;
    end
    check("t2_fd_cycle",  0, 32'(fdk),   32'd134);
    check("t2_load_low",  0, 32'(lows),  32'd8);
    check("t2_rises",     0, 32'(rises), 32'd16);
    check("t2_first",     0, 32'(first), 32'd13);
    check("t2_last",      0, 32'(last),  32'd133);
    check("t2_gap_min",   0, 32'(gmin),  32'd8);
    check("t2_gap_max",   0, 32'(gmax),  32'd8);
    check("t2_ctrl",      0, 32'(cd_a),  32'h0000A55A);
    check("t2_changed",   0, 32'(ch_a),  32'd3);

    // Back-to-back frames with scan_en held
    for (int f = 0; f < 3; f++) begin
      check("t6_load_at_fd", 0, 32'(loadn[0]), 32'd0);
      wait_fd(0, k);
      check("t6_period", 0, 32'(k), 32'd133);
      check("t6_changed", 0, 32'(ch_a), 32'd0);
    end

    // Drop scan_en at 5th rising edge: frame completes, then idle
    pattern[0] = 18'h01234;
    k = 0; rises = 0; fds = 0; prev_h = 1'b0;
    while (fds == 0 && k < 400) begin
      tick(1);
      k++;
      if (hclk[0] && !prev_h) begin
        rises++;
        if (rises == 5) en[0] = 1'b0;
      end
      prev_h = hclk[0];
      if (fdone[0]) fds = 1;
    end
    check("t4_fd_seen", 0, 32'(fds),   32'd1);
    check("t4_rises",   0, 32'(rises), 32'd16);
    check("t4_ctrl",    0, 32'(cd_a),  32'h00001234);
    check("t4_changed", 0, 32'(ch_a),  32'd3);
    rises = 0; lows = 0; fds = 0;
    repeat (300) begin
      tick(1);
      if (hclk[0] && !prev_h) rises++;
      prev_h = hclk[0];
      if (!loadn[0]) lows++;
      if (fdone[0]) fds++;
    end
    check("t4_idle_rises", 0, 32'(rises), 32'd0);
    check("t4_idle_load",  0, 32'(lows),  32'd0);
    check("t4_idle_fd",    0, 32'(fds),   32'd0);

    // Debounce with DEBOUNCE=2
    pattern[1] = 18'h0FFFE;
    en[1] = 1'b1;
    wait_fd(1, k);
    check("t3_f1_ctrl", 1, 32'(cd_b), 32'h0000FFFF);
    check("t3_f1_chg",  1, 32'(ch_b), 32'd0);
    pattern[1] = 18'h0FFFF;
    wait_fd(1, k);
    check("t3_f2_ctrl", 1, 32'(cd_b), 32'h0000FFFF);
    check("t3_f2_chg",  1, 32'(ch_b), 32'd0);
    pattern[1] = 18'h0FF7F;
    wait_fd(1, k);
    check("t3_f3_ctrl", 1, 32'(cd_b), 32'h0000FFFF);
    check("t3_f3_chg",  1, 32'(ch_b), 32'd0);
    wait_fd(1, k);
    check("t3_f4_ctrl", 1, 32'(cd_b), 32'h0000FF7F);
    check("t3_f4_chg",  1, 32'(ch_b), 32'd1);
    en[1] = 1'b0;
    wait_fd(1, k);
    check("t3_f5_ctrl", 1, 32'(cd_b), 32'h0000FF7F);
    check("t3_f5_chg",  1, 32'(ch_b), 32'd0);

    // Three controllers of six bits
    pattern[2] = 18'h2AAAA;
    en[2] = 1'b1;
    wait_fd(2, k);
    check("t5_period1", 2, 32'(k),    32'd150);
    check("t5_f1_ctrl", 2, 32'(cd_c), 32'h0002AAAA);
    check("t5_f1_chg",  2, 32'(ch_c), 32'd7);
    en[2] = 1'b0;
    wait_fd(2, k);
    check("t5_period2", 2, 32'(k),    32'd149);
    check("t5_f2_fd",   2, 32'(fdone[2]), 32'd1);
    check("t5_f2_ctrl", 2, 32'(cd_c), 32'h0002AAAA);
    check("t5_f2_chg",  2, 32'(ch_c), 32'd0);

    // Reset in the middle of SHIFT
    en[0] = 1'b1;
    tick(30);
    reset = 1'b1;
    tick(1);
    check("t1_ldn",  0, 32'(loadn[0]), 32'd1);
    check("t1_clk",  0, 32'(hclk[0]),  32'd0);
    check("t1_ctrl", 0, 32'(cd_a),     32'h0000FFFF);
    reset = 1'b0;
    en[0] = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
